// File: rtl/hft_pkg.sv
// Shared sizes, edge-update record and scheduler state encoding for the Bellman arbitrage path.
package hft_pkg;

  localparam int NODES  = 64;
  localparam int NODE_W = 7;
  localparam int EDGE_W = 32;

  typedef struct packed {
    logic [NODE_W-1:0] row;
    logic [NODE_W-1:0] col;
    logic [EDGE_W-1:0] weight;
  } edge_upd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_REPORT
  } sched_state_t;

endpackage

// File: rtl/upd_fifo.sv
// Synchronous FIFO of edge updates; read data is the head entry (zero-latency show-ahead).
// full/empty come from the registered count, so a pop frees a slot only from the next cycle.
module upd_fifo import hft_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  edge_upd_t push_dat,
  input  logic      pop,
  output edge_upd_t pop_dat,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  edge_upd_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     cnt_q;
  logic [AW:0]     cnt_d;
  logic            do_push;
  logic            do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/bellman_sched.sv
// Bellman engine sequencer: applies queued edge updates only while idle, then runs up to NODES passes.
// Optional BELLMAN_AUTO_RERUN_EN: updates left queued at report time re-run the last source automatically.
module bellman_sched #(
  parameter int NODES      = hft_pkg::NODES,
  parameter int W          = hft_pkg::EDGE_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [hft_pkg::NODE_W-1:0] upd_row,
  input  logic [hft_pkg::NODE_W-1:0] upd_col,
  input  logic [W-1:0]               upd_weight,
  input  logic                       run_req,
  input  logic [hft_pkg::NODE_W-1:0] run_src,
  output logic                       eng_start,
  output logic                       eng_init,
  output logic [hft_pkg::NODE_W-1:0] eng_src,
  input  logic                       eng_done,
  input  logic                       eng_changed,
  output logic                       adj_we,
  output logic [hft_pkg::NODE_W-1:0] adj_row,
  output logic [hft_pkg::NODE_W-1:0] adj_col,
  output logic [W-1:0]               adj_wdata,
  output logic                       busy,
  output logic                       result_valid,
  output logic                       neg_cycle,
  output logic [hft_pkg::NODE_W-1:0] pass_cnt
);

  import hft_pkg::*;

  localparam logic [NODE_W-1:0] LAST_PASS = NODE_W'(NODES);

  sched_state_t      state_q;
  edge_upd_t         push_dat;
  edge_upd_t         pop_dat;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              pend_q;
  logic [NODE_W-1:0] pend_src_q;
  logic              guard_q;
  logic              changed_q;
  logic              eng_start_q;
  logic              eng_init_q;
  logic [NODE_W-1:0] eng_src_q;
  logic              adj_we_q;
  logic [NODE_W-1:0] adj_row_q;
  logic [NODE_W-1:0] adj_col_q;
  logic [W-1:0]      adj_wdata_q;
  logic              busy_q;
  logic              result_valid_q;
  logic              neg_cycle_q;
  logic [NODE_W-1:0] pass_cnt_q;

  assign push_dat = '{row: upd_row, col: upd_col, weight: upd_weight};
  assign fifo_pop = (state_q == S_DRAIN) && !fifo_empty;

  upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (upd_valid),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign upd_ready    = !fifo_full;
  assign eng_start    = eng_start_q;
  assign eng_init     = eng_init_q;
  assign eng_src      = eng_src_q;
  assign adj_we       = adj_we_q;
  assign adj_row      = adj_row_q;
  assign adj_col      = adj_col_q;
  assign adj_wdata    = adj_wdata_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign neg_cycle    = neg_cycle_q;
  assign pass_cnt     = pass_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pend_q         <= 1'b0;
      pend_src_q     <= '0;
      guard_q        <= 1'b0;
      changed_q      <= 1'b0;
      eng_start_q    <= 1'b0;
      eng_init_q     <= 1'b0;
      eng_src_q      <= '0;
      adj_we_q       <= 1'b0;
      adj_row_q      <= '0;
      adj_col_q      <= '0;
      adj_wdata_q    <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      neg_cycle_q    <= 1'b0;
      pass_cnt_q     <= '0;
    end else begin
      // Any request not launched directly this cycle is parked; a newer one overwrites the source.
      if (run_req) begin
        pend_q     <= 1'b1;
        pend_src_q <= run_src;
      end
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            state_q <= S_DRAIN;
          end else if (run_req || pend_q) begin
            state_q     <= S_LAUNCH;
            eng_start_q <= 1'b1;
            eng_init_q  <= 1'b1;
            eng_src_q   <= run_req ? run_src : pend_src_q;
            pend_q      <= 1'b0;
            pass_cnt_q  <= '0;
            busy_q      <= 1'b1;
          end
        end
        S_DRAIN: begin
          adj_we_q <= !fifo_empty;
          if (fifo_empty) begin
            state_q <= S_IDLE;
          end else begin
            adj_row_q   <= pop_dat.row;
            adj_col_q   <= pop_dat.col;
            adj_wdata_q <= pop_dat.weight;
          end
        end
        S_LAUNCH: begin
          eng_start_q <= 1'b0;
          eng_init_q  <= 1'b0;
          pass_cnt_q  <= pass_cnt_q + NODE_W'(1);
          guard_q     <= 1'b1;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          // done may still show the previous pass until the engine registers the start
          if (guard_q) begin
            guard_q <= 1'b0;
          end else if (eng_done) begin
            changed_q <= eng_changed;
            state_q   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!changed_q) begin
            neg_cycle_q    <= 1'b0;
            result_valid_q <= 1'b1;
            state_q        <= S_REPORT;
          end else if (pass_cnt_q < LAST_PASS) begin
            eng_start_q <= 1'b1;
            eng_init_q  <= 1'b0;
            state_q     <= S_LAUNCH;
          end else begin
            neg_cycle_q    <= 1'b1;
            result_valid_q <= 1'b1;
            state_q        <= S_REPORT;
          end
        end
        S_REPORT: begin
          result_valid_q <= 1'b0;
          busy_q         <= 1'b0;
          state_q        <= S_IDLE;
`ifdef BELLMAN_AUTO_RERUN_EN
          if (!fifo_empty && !run_req) begin
            pend_q     <= 1'b1;
            pend_src_q <= eng_src_q;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bellman_sched.sv
// Self-checking bench for bellman_sched with NODES=8, a randomised engine model and a solve-outcome reference.
module tb_bellman_sched;

  localparam int NODES = 8;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         upd_valid = 1'b0;
  logic         upd_ready;
  logic [6:0]   upd_row = '0;
  logic [6:0]   upd_col = '0;
  logic [W-1:0] upd_weight = '0;
  logic         run_req = 1'b0;
  logic [6:0]   run_src = '0;
  logic         eng_start;
  logic         eng_init;
  logic [6:0]   eng_src;
  logic         eng_done = 1'b1;
  logic         eng_changed = 1'b0;
  logic         adj_we;
  logic [6:0]   adj_row;
  logic [6:0]   adj_col;
  logic [W-1:0] adj_wdata;
  logic         busy;
  logic         result_valid;
  logic         neg_cycle;
  logic [6:0]   pass_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bellman_sched #(.NODES(NODES), .W(W), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_row(upd_row), .upd_col(upd_col), .upd_weight(upd_weight),
    .run_req(run_req), .run_src(run_src),
    .eng_start(eng_start), .eng_init(eng_init), .eng_src(eng_src),
    .eng_done(eng_done), .eng_changed(eng_changed),
    .adj_we(adj_we), .adj_row(adj_row), .adj_col(adj_col), .adj_wdata(adj_wdata),
    .busy(busy), .result_valid(result_valid), .neg_cycle(neg_cycle), .pass_cnt(pass_cnt)
  );

  // Engine model: done drops as a registered response to start, returns after a random latency.
  bit chg_pat [16];
  bit chg_all = 1'b0;
  int pass_idx = 0;
  int eng_lat = 0;
  bit eng_run = 1'b0;

  always @(posedge clk) begin
    if (eng_start) begin
      eng_done <= 1'b0;
      eng_run  <= 1'b1;
      eng_lat  <= $urandom_range(0, 3);
      if (eng_init) pass_idx <= 0;
    end else if (eng_run) begin
      if (eng_lat == 0) begin
        eng_done    <= 1'b1;
        eng_changed <= chg_all ? 1'b1 : chg_pat[pass_idx];
        pass_idx    <= pass_idx + 1;
        eng_run     <= 1'b0;
      end else begin
        eng_lat <= eng_lat - 1;
      end
    end
  end

  // Event logs, sampled on the falling edge.
  logic [45:0] wr_q[$];
  int          wr_cyc[$];
  bit          st_init[$];
  logic [6:0]  st_src[$];
  int          st_cyc[$];
  bit          res_neg[$];
  logic [6:0]  res_pc[$];
  int          res_cyc[$];
  logic [45:0] exp_wr[$];
  int          overlap = 0;
  int          we_busy = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (adj_we) begin
        wr_q.push_back({adj_row, adj_col, adj_wdata});
        wr_cyc.push_back(cyc);
      end
      if (eng_start) begin
        st_init.push_back(eng_init);
        st_src.push_back(eng_src);
        st_cyc.push_back(cyc);
      end
      if (result_valid) begin
        res_neg.push_back(neg_cycle);
        res_pc.push_back(pass_cnt);
        res_cyc.push_back(cyc);
      end
      if (adj_we && eng_start) overlap++;
      if (adj_we && busy) we_busy++;
    end
  end

  task automatic clear_logs();
    wr_q.delete(); wr_cyc.delete(); st_init.delete(); st_src.delete(); st_cyc.delete();
    res_neg.delete(); res_pc.delete(); res_cyc.delete(); exp_wr.delete();
  endtask

  task automatic push_upd(input logic [6:0] r, input logic [6:0] c, input logic [31:0] w);
    upd_valid = 1'b1; upd_row = r; upd_col = c; upd_weight = w;
    exp_wr.push_back({r, c, w});
    @(posedge clk);
    #1 upd_valid = 1'b0;
  endtask

  task automatic run(input logic [6:0] src);
    run_req = 1'b1; run_src = src;
    @(posedge clk);
    #1 run_req = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_res(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && res_neg.size() < n; i++) @(posedge clk);
    #1;
    total++;
    if (res_neg.size() < n) begin
      bad++;
      $display("FAIL %s_timeout: results seen %0d, required %0d", tag, res_neg.size(), n);
    end
  endtask

  // Reference: a solve stops at the first unchanged pass, otherwise runs NODES passes and flags a cycle.
  task automatic ref_solve(output int passes, output bit neg);
    passes = NODES;
    neg = 1'b1;
    for (int k = 0; k < NODES; k++) begin
      if (!chg_all && !chg_pat[k]) begin
        passes = k + 1;
        neg = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    settle(3);
    total++;
    if ({eng_start, eng_init, adj_we, busy, result_valid, neg_cycle, pass_cnt, eng_src} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 0",
               {eng_start, eng_init, adj_we, busy, result_valid, neg_cycle, pass_cnt, eng_src});
    end
    total++;
    if (upd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b required 1", upd_ready); end
    rst_n = 1'b1;
    settle(2);
  endtask

  task automatic test_drain_order();
    clear_logs();
    chg_all = 1'b0;
    chg_pat = '{default: 1'b0};
    chg_pat[0] = 1'b1; chg_pat[1] = 1'b1;
    push_upd(7'd1, 7'd2, 32'd5);
    push_upd(7'd2, 7'd3, 32'hFFFF_FFFC);
    push_upd(7'd3, 7'd1, 32'd7);
    run(7'd1);
    wait_res(1, 500, "drain");
    settle(4);
    total++;
    if (wr_q.size() != 3) begin bad++; $display("FAIL drain_count: got %0d required 3", wr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (wr_q.size() <= i || wr_q[i] !== exp_wr[i]) begin
        bad++;
        $display("FAIL drain_entry%0d: got %h required %h", i, (wr_q.size() > i) ? wr_q[i] : 46'h0, exp_wr[i]);
      end
    end
    total++;
    if (wr_cyc.size() != 3 || wr_cyc[2] - wr_cyc[0] != 2 || st_cyc.size() == 0 || wr_cyc[2] >= st_cyc[0]) begin
      bad++;
      $display("FAIL drain_timing: writes %0d, not consecutive or not before first start", wr_cyc.size());
    end
    total++;
    if (st_cyc.size() != 3) begin bad++; $display("FAIL conv_starts: got %0d required 3", st_cyc.size()); end
    total++;
    if (st_init.size() == 0 || st_init[0] !== 1'b1 || st_src[0] !== 7'd1) begin
      bad++;
      $display("FAIL first_start: init/src got %b/%0d required 1/1",
               (st_init.size() > 0) ? st_init[0] : 1'b0, (st_src.size() > 0) ? st_src[0] : 7'h7f);
    end
    total++;
    if (res_neg.size() == 0 || res_neg[0] !== 1'b0 || res_pc[0] !== 7'd3) begin
      bad++;
      $display("FAIL conv_result: neg/pass got %b/%0d required 0/3",
               (res_neg.size() > 0) ? res_neg[0] : 1'b1, (res_pc.size() > 0) ? res_pc[0] : 7'h7f);
    end
  endtask

  task automatic test_detect();
    clear_logs();
    chg_all = 1'b1;
    run(7'd3);
    wait_res(1, 800, "detect");
    settle(4);
    total++;
    if (st_cyc.size() != NODES) begin bad++; $display("FAIL detect_starts: got %0d required %0d", st_cyc.size(), NODES); end
    total++;
    if (res_neg.size() == 0 || res_neg[0] !== 1'b1 || res_pc[0] !== 7'(NODES)) begin
      bad++;
      $display("FAIL detect_result: neg/pass got %b/%0d required 1/%0d",
               (res_neg.size() > 0) ? res_neg[0] : 1'b0, (res_pc.size() > 0) ? res_pc[0] : 7'h7f, NODES);
    end
    total++;
    if (st_init.size() < 2 || st_init[1] !== 1'b0) begin bad++; $display("FAIL detect_reinit: second start init got 1 or missing, required 0"); end
  endtask

  task automatic test_busy_updates();
    logic [31:0] w;
    clear_logs();
    chg_all = 1'b1;
    run(7'd2);
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      if (i == 7) begin
        total++;
        if (upd_ready !== 1'b1) begin bad++; $display("FAIL ready_before_full: got %b required 1", upd_ready); end
      end
      push_upd(7'(i), 7'(7 - i), w);
    end
    total++;
    if (upd_ready !== 1'b0) begin bad++; $display("FAIL ready_full: got %b required 0", upd_ready); end
    total++;
    if (wr_q.size() != 0 || busy !== 1'b1) begin bad++; $display("FAIL write_while_busy: writes %0d busy %b", wr_q.size(), busy); end
`ifdef BELLMAN_AUTO_RERUN_EN
    wait_res(2, 1600, "auto_rerun");
    settle(4);
    total++;
    if (st_init.size() <= NODES || st_init[NODES] !== 1'b1 || st_src[NODES] !== 7'd2 || st_cyc[NODES] <= wr_cyc[7]) begin
      bad++;
      $display("FAIL auto_rerun: starts %0d, rerun start missing, not init, wrong src or before drain", st_init.size());
    end
`else
    wait_res(1, 800, "busy_solve");
    settle(20);
    total++;
    if (res_neg.size() != 1 || st_cyc.size() != NODES) begin
      bad++;
      $display("FAIL no_rerun: results %0d starts %0d required 1 and %0d", res_neg.size(), st_cyc.size(), NODES);
    end
`endif
    total++;
    if (wr_q.size() != 8) begin bad++; $display("FAIL busy_drain_count: got %0d required 8", wr_q.size()); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (wr_q.size() <= i || wr_q[i] !== exp_wr[i]) begin
        bad++;
        $display("FAIL busy_entry%0d: got %h required %h", i, (wr_q.size() > i) ? wr_q[i] : 46'h0, exp_wr[i]);
      end
    end
    total++;
    if (wr_cyc.size() != 8 || wr_cyc[7] - wr_cyc[0] != 7 || res_cyc.size() == 0 || wr_cyc[0] <= res_cyc[0]) begin
      bad++;
      $display("FAIL busy_drain_timing: writes %0d not 8 consecutive after REPORT", wr_cyc.size());
    end
    total++;
    if (upd_ready !== 1'b1) begin bad++; $display("FAIL ready_after_drain: got %b required 1", upd_ready); end
  endtask

  task automatic test_reset_mid_wait();
    clear_logs();
    chg_all = 1'b1;
    run(7'd1);
    for (int i = 0; i < 400 && st_cyc.size() < 3; i++) @(posedge clk);
    #1;
    total++;
    if (st_cyc.size() != 3) begin bad++; $display("FAIL midwait_reach: starts %0d required 3", st_cyc.size()); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({eng_start, eng_init, adj_we, busy, result_valid, neg_cycle, pass_cnt, eng_src} !== 20'h0 || upd_ready !== 1'b1) begin
      bad++;
      $display("FAIL midwait_reset: outputs %h ready %b required 0 and 1",
               {eng_start, eng_init, adj_we, busy, result_valid, neg_cycle, pass_cnt, eng_src}, upd_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    settle(12);
    total++;
    if (res_neg.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL abandoned_solve: results %0d busy %b required 0/0", res_neg.size(), busy); end
    clear_logs();
    chg_all = 1'b0;
    chg_pat = '{default: 1'b0};
    chg_pat[0] = 1'b1;
    run(7'd6);
    wait_res(1, 500, "post_reset");
    settle(4);
    total++;
    if (st_init.size() != 2 || st_init[0] !== 1'b1 || st_src[0] !== 7'd6) begin
      bad++;
      $display("FAIL post_reset_launch: starts %0d init %b src %0d required 2/1/6",
               st_init.size(), (st_init.size() > 0) ? st_init[0] : 1'b0, (st_src.size() > 0) ? st_src[0] : 7'h7f);
    end
    total++;
    if (res_pc.size() == 0 || res_pc[0] !== 7'd2 || res_neg[0] !== 1'b0) begin bad++; $display("FAIL post_reset_result: pass/neg wrong, required 2/0"); end
  endtask

  task automatic test_pending();
    clear_logs();
    chg_all = 1'b0;
    chg_pat = '{default: 1'b0};
    chg_pat[0] = 1'b1; chg_pat[1] = 1'b1;
    run(7'd2);
    settle(2);
    run(7'd4);
    settle(1);
    run(7'd5);
    wait_res(2, 1000, "pending");
    settle(12);
    total++;
    if (res_neg.size() != 2 || st_cyc.size() != 6) begin
      bad++;
      $display("FAIL pending_count: results %0d starts %0d required 2 and 6", res_neg.size(), st_cyc.size());
    end
    total++;
    if (st_src.size() < 4 || st_src[0] !== 7'd2 || st_src[3] !== 7'd5 || st_init[3] !== 1'b1 || st_cyc[3] <= res_cyc[0]) begin
      bad++;
      $display("FAIL pending_src: second solve src %0d required 5 after first report", (st_src.size() > 3) ? st_src[3] : 7'h7f);
    end
    total++;
    if (res_pc.size() < 2 || res_pc[1] !== 7'd3 || res_neg[1] !== 1'b0) begin bad++; $display("FAIL pending_result: second result wrong, required 3/0"); end
  endtask

  task automatic test_random();
    int nupd;
    int exp_p;
    bit exp_n;
    int inits;
    logic [6:0] src;
    for (int it = 0; it < 10; it++) begin
      clear_logs();
      nupd = $urandom_range(0, 6);
      chg_all = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 16; k++) chg_pat[k] = ($urandom_range(0, 2) != 0);
      src = 7'($urandom_range(0, NODES - 1));
      for (int u = 0; u < nupd; u++) push_upd(7'($urandom_range(0, NODES - 1)), 7'($urandom_range(0, NODES - 1)), $urandom);
      run(src);
      ref_solve(exp_p, exp_n);
      wait_res(1, 1000, "random");
      settle(4);
      inits = 0;
      foreach (st_init[j]) inits += int'(st_init[j]);
      total++;
      if (wr_q != exp_wr) begin bad++; $display("FAIL rnd%0d_writes: got %0d entries required %0d in push order", it, wr_q.size(), exp_wr.size()); end
      total++;
      if (st_cyc.size() != exp_p || inits != 1) begin bad++; $display("FAIL rnd%0d_starts: got %0d (inits %0d) required %0d (1)", it, st_cyc.size(), inits, exp_p); end
      total++;
      if (st_src.size() == 0 || st_src[0] !== src || st_init[0] !== 1'b1) begin bad++; $display("FAIL rnd%0d_src: first start src wrong, required %0d", it, src); end
      total++;
      if (res_pc.size() != 1 || res_pc[0] !== 7'(exp_p) || res_neg[0] !== exp_n) begin
        bad++;
        $display("FAIL rnd%0d_result: pass/neg got %0d/%b required %0d/%b", it,
                 (res_pc.size() > 0) ? res_pc[0] : 7'h7f, (res_neg.size() > 0) ? res_neg[0] : 1'b0, exp_p, exp_n);
      end
    end
  endtask

  task automatic test_exclusive();
    total++;
    if (overlap != 0 || we_busy != 0) begin
      bad++;
      $display("FAIL exclusive: we+start cycles %0d, we-while-busy cycles %0d, required 0/0", overlap, we_busy);
    end
  endtask

  initial begin
    test_reset();
    test_drain_order();
    test_detect();
    test_busy_updates();
    test_reset_mid_wait();
    test_pending();
    test_random();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/bellman_sched.md
Name: bellman_sched

Overview:
- Sequencing controller for the Bellman relaxation engine in the arbitrage path.
- Queues edge-weight updates from the market-data decoder and applies them to the adjacency-matrix write port only while the engine is idle.
- Launches the engine for up to NODES-1 relaxation passes plus one detection pass, stopping early on convergence.
- Reports whether a negative cycle (arbitrage opportunity) exists from the selected source node.

Parameters:
- NODES, 64, vertex count; node indices are 7 bits.
- W, 32, edge-weight and distance width.
- FIFO_DEPTH, 8, update-queue depth; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- upd_valid  in  1  edge update offered
- upd_ready  out  1  update queue can accept (!full)
- upd_row  in  7  adjacency row index
- upd_col  in  7  adjacency column index
- upd_weight  in  W  new edge weight
- run_req  in  1  one-cycle request to solve
- run_src  in  7  source node, sampled with run_req
- eng_start  out  1  one-cycle engine launch pulse
- eng_init  out  1  valid with eng_start; 1 = engine re-initialises distances from eng_src
- eng_src  out  7  source node to engine
- eng_done  in  1  engine pass complete (level)
- eng_changed  in  1  any distance decreased in last pass; valid while eng_done=1
- adj_we  out  1  adjacency write strobe
- adj_row  out  7  adjacency write row
- adj_col  out  7  adjacency write column
- adj_wdata  out  W  adjacency write data
- busy  out  1  solve in progress
- result_valid  out  1  one-cycle result strobe
- neg_cycle  out  1  negative cycle found; held until next result
- pass_cnt  out  7  passes executed in the last solve; held

Behaviour:
- Reset (asynchronous, any state):
  - eng_start, eng_init, adj_we, busy, result_valid, neg_cycle, pass_cnt, eng_src = 0.
  - Queue empty, so upd_ready=1.
  - Pending-run latch cleared; state = IDLE.
  - A pass already in flight in the engine is abandoned. The next launch always has eng_init=1.
- Update queue:
  - Push when upd_valid && upd_ready.
  - upd_ready = !full, computed from the start-of-cycle count. A pop in the same cycle does not raise ready until the next cycle.
  - Push and pop in the same cycle leave the count unchanged.
- State machine:
  - IDLE:
    - Queue non-empty -> DRAIN.
    - Otherwise, run_req or pending latch -> LAUNCH with eng_init=1; latch run_src into eng_src; pass_cnt=0; busy=1.
  - DRAIN:
    - Pop one entry per cycle; drive adj_we=1 with its row, column and weight for exactly that cycle.
    - Queue empty -> IDLE. Any run request is served from IDLE afterwards, so all updates queued before the request are applied first.
  - LAUNCH: eng_start=1 for one cycle; pass_cnt+1 -> WAIT.
  - WAIT:
    - eng_done is ignored in the launch cycle and the cycle after it, because the engine clears done as a registered response to start.
    - Afterwards, on eng_done=1 -> CHECK.
  - CHECK:
    - eng_changed=0 -> REPORT with neg_cycle=0 (converged).
    - eng_changed=1 and pass_cnt < NODES -> LAUNCH with eng_init=0.
    - eng_changed=1 and pass_cnt == NODES (the detection pass) -> REPORT with neg_cycle=1.
  - REPORT: result_valid=1 for one cycle; busy=0 -> IDLE.
- Requests while busy:
  - run_req while busy sets the one-deep pending latch, storing run_src.
  - A second request overwrites the stored source; it is not counted.
- Updates while busy: accepted into the queue but never written while busy=1, so the matrix is stable during a solve.
- adj_we and eng_start are never asserted in the same cycle.

Optional Feature:
- Macro: BELLMAN_AUTO_RERUN_EN.
- Defined: in REPORT, if the queue is non-empty, the pending latch is set automatically with the previous eng_src. The solve re-runs after DRAIN without run_req.
- Undefined: solves start only from run_req or an explicitly latched request.

Decomposition:
- Shared package hft_pkg:
  - Constants NODES and NODE_W=7.
  - Struct edge_upd_t {row, col, weight}.
  - Enum sched_state_t.
- Sub-module upd_fifo: a parameterised synchronous FIFO of edge_upd_t with async active-low reset, push/pop, and full/empty flags.

Test Plan (NODES=8):
- Reset mid-WAIT (rst_n low for 1 cycle during pass 3):
  - All outputs return to 0 and upd_ready=1.
  - Next run_req launches with eng_init=1.
- Push 3 updates ((1,2,5),(2,3,-4),(3,1,7)), then run_req src=1:
  - Three consecutive adj_we cycles, in that order, before the first eng_start.
  - First eng_start has eng_init=1 and eng_src=1.
- Engine model reports eng_changed=1,1,0:
  - Three eng_start pulses; result_valid with neg_cycle=0 and pass_cnt=3.
- Engine model reports eng_changed=1 on every pass:
  - Exactly 8 eng_start pulses (7 relaxation + 1 detection); neg_cycle=1; pass_cnt=8.
- Push 8 updates while busy:
  - upd_ready drops after the 8th push; adj_we stays 0 until REPORT.
  - The queue then drains in 8 cycles.
- run_req src=5 issued during a solve from src=2:
  - After REPORT, a second solve launches with eng_src=5.
  - With BELLMAN_AUTO_RERUN_EN and queued updates, a rerun occurs with no run_req.
